tcp_tx_framer: RTL and testbench

TCP_TX_FRAMER -- requirements
Module: tcp_tx_framer

---
 rtl/tcp_tx_framer.sv | 211 +++++++++++++++++++++
 tb/tb_tcp_tx_framer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_framer.sv
// Purpose : packs 32-bit event words into byte frames for a TCP TX buffer:
//           HDR_WORD(2) SEQ(2) payload(4/word) WCNT(2) [CHK(1)], all MSB first.
// Latency : TCP_TX_WR/TCP_TX_DATA are registered, 1 cycle after the emit decision;
//           an unthrottled word takes 5 cycles (1 LOAD + 4 BYTE).
// Backpr. : TCP_TX_FULL=1 stalls emission and holds the byte index; EVT_READY
//           is raised only in LOAD (with TCP_OPEN=1) and in FLUSH.
//
// Ports   : CLK/RST       single clock, synchronous active-high reset
//           TCP_OPEN      connection up; falling mid-frame aborts the frame
//           TCP_TX_FULL   TX buffer almost full
//           TCP_TX_WR/DATA byte write strobe and byte to the TX buffer
//           EVT_VALID/DATA/LAST/READY  upstream word handshake
//           FRAME_CNT/ABORT_CNT  wrapping completed/aborted frame counters
// Option  : define TCP_TX_FRAMER_CHKSUM_EN to append an XOR-of-payload CHK byte.
module tcp_tx_framer #(
  parameter logic [15:0] HDR_WORD = 16'hAA55
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TCP_OPEN,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  input  logic        EVT_VALID,
  input  logic [31:0] EVT_DATA,
  input  logic        EVT_LAST,
  output logic        EVT_READY,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ABORT_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    BYTE,
    TRL,
`ifdef TCP_TX_FRAMER_CHKSUM_EN
    CHK,
`endif
    FLUSH
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;        // byte index inside the current field
  logic [31:0] word;       // latched payload word, shifted left as bytes go out
  logic        last_seen;  // EVT_LAST already accepted for the current frame
  logic [15:0] wcnt;
  logic [15:0] seq;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;
  logic        tx_wr;
  logic [7:0]  tx_data;
`ifdef TCP_TX_FRAMER_CHKSUM_EN
  logic [7:0]  chk;
`endif

  logic        emit;
  logic [7:0]  emit_byte;
  logic        evt_rdy;
  logic        load_word;
  logic        frame_done;
  logic        abort;
  logic        frame_start;

  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    emit_byte  = 8'h00;
    evt_rdy    = 1'b0;
    load_word  = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // The word is not consumed here; LOAD picks it up after the header.
        if (EVT_VALID && TCP_OPEN) state_nxt = HDR;
      end
      HDR: begin
        if (!TCP_OPEN) begin
          abort = 1'b1;
        end else if (!TCP_TX_FULL) begin
          emit = 1'b1;
          case (idx)
            2'd0:    emit_byte = HDR_WORD[15:8];
            2'd1:    emit_byte = HDR_WORD[7:0];
            2'd2:    emit_byte = seq[15:8];
            default: emit_byte = seq[7:0];
          endcase
          if (idx == 2'd3) state_nxt = LOAD;
        end
      end
      LOAD: begin
        // READY is gated by TCP_OPEN so no word is taken on the abort cycle.
        if (!TCP_OPEN) begin
          abort = 1'b1;
        end else begin
          evt_rdy = 1'b1;
          if (EVT_VALID) begin
            load_word = 1'b1;
            state_nxt = BYTE;
          end
        end
      end
      BYTE: begin
        if (!TCP_OPEN) begin
          abort = 1'b1;
        end else if (!TCP_TX_FULL) begin
          emit      = 1'b1;
          emit_byte = word[31:24];
          if (idx == 2'd3) state_nxt = last_seen ? TRL : LOAD;
        end
      end
      TRL: begin
        if (!TCP_OPEN) begin
          abort = 1'b1;
        end else if (!TCP_TX_FULL) begin
          emit      = 1'b1;
          emit_byte = idx[0] ? wcnt[7:0] : wcnt[15:8];
          if (idx[0]) begin
`ifdef TCP_TX_FRAMER_CHKSUM_EN
            state_nxt = CHK;
`else
            state_nxt  = IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef TCP_TX_FRAMER_CHKSUM_EN
      CHK: begin
        if (!TCP_OPEN) begin
          abort = 1'b1;
        end else if (!TCP_TX_FULL) begin
          emit       = 1'b1;
          emit_byte  = chk;
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      FLUSH: begin
        // Drain the rest of the aborted frame regardless of TCP_OPEN.
        evt_rdy = 1'b1;
        if (EVT_VALID && EVT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = last_seen ? IDLE : FLUSH;
  end

  // Per-frame state is also cleared on IDLE->HDR so an abort on the very first
  // header cycle never sees last_seen left over from the previous frame.
  assign frame_start = (state == HDR) || (state_nxt == HDR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= 2'd0;
      word      <= 32'h0;
      last_seen <= 1'b0;
      wcnt      <= 16'h0;
      seq       <= 16'h0;
      frame_cnt <= 16'h0;
      abort_cnt <= 16'h0;
      tx_wr     <= 1'b0;
      tx_data   <= 8'h00;
`ifdef TCP_TX_FRAMER_CHKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      state <= state_nxt;

      if (state_nxt != state) idx <= 2'd0;
      else if (emit)          idx <= idx + 2'd1;

      tx_wr <= emit;
      if (emit) tx_data <= emit_byte;

      if (load_word)                  word <= EVT_DATA;
      else if (emit && state == BYTE) word <= {word[23:0], 8'h00};

      if (frame_start) begin
        wcnt      <= 16'h0;
        last_seen <= 1'b0;
      end else if (load_word) begin
        wcnt      <= wcnt + 16'd1;
        last_seen <= EVT_LAST;
      end

`ifdef TCP_TX_FRAMER_CHKSUM_EN
      if (frame_start)    chk <= 8'h00;
      else if (load_word) chk <= chk ^ EVT_DATA[31:24] ^ EVT_DATA[23:16]
                                     ^ EVT_DATA[15:8]  ^ EVT_DATA[7:0];
`endif

      if (frame_done) begin
        seq       <= seq + 16'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (abort) abort_cnt <= abort_cnt + 16'd1;
    end
  end

  assign TCP_TX_WR   = tx_wr;
  assign TCP_TX_DATA = tx_data;
  assign EVT_READY   = evt_rdy;
  assign FRAME_CNT   = frame_cnt;
  assign ABORT_CNT   = abort_cnt;

endmodule

// File: tb/tb_tcp_tx_framer.sv
// Bench for tcp_tx_framer: queue-based word source, byte capture monitor and a
// frame-level reference model that builds the expected byte stream per frame.
// Optional checksum byte follows TCP_TX_FRAMER_CHKSUM_EN like the design.
module tb_tcp_tx_framer;

  localparam logic [15:0] HDR = 16'hAA55;
  typedef logic [31:0] wq_t[$];

  logic        clk;
  logic        rst;
  logic        tcp_open;
  logic        tx_full;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        evt_vld;
  logic [31:0] evt_dat;
  logic        evt_last;
  logic        evt_rdy;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc[$];
  int          wr_in_full = 0;
  logic        full_s = 1'b0;
  logic        hs;
  int          hs_cyc;
  logic [32:0] src_q[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] seq_m;
  logic [15:0] fcnt_m;

  tcp_tx_framer #(.HDR_WORD(HDR)) dut (
    .CLK         (clk),
    .RST         (rst),
    .TCP_OPEN    (tcp_open),
    .TCP_TX_FULL (tx_full),
    .TCP_TX_WR   (tx_wr),
    .TCP_TX_DATA (tx_data),
    .EVT_VALID   (evt_vld),
    .EVT_DATA    (evt_dat),
    .EVT_LAST    (evt_last),
    .EVT_READY   (evt_rdy),
    .FRAME_CNT   (frame_cnt),
    .ABORT_CNT   (abort_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    full_s = tx_full;
  end

  // Byte monitor: registered outputs are read mid-cycle.
  initial forever begin
    @(negedge clk);
    if (tx_wr === 1'b1) begin
      cap_q.push_back(tx_data);
      if (full_s) wr_in_full++;
    end
  end

  // Word source: presents the queue head, pops it when the handshake fires.
  initial begin
    evt_vld  = 1'b0;
    evt_dat  = 32'h0;
    evt_last = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (src_q.size() > 0) begin
        evt_vld = 1'b1;
        {evt_last, evt_dat} = src_q[0];
      end else begin
        evt_vld  = 1'b0;
        evt_last = 1'b0;
        evt_dat  = 32'h0;
      end
      #1;
      hs     = evt_vld && (evt_rdy === 1'b1);
      hs_cyc = cyc;
      @(posedge clk);
      if (hs) begin
        if (src_q.size() > 0) src_q.delete(0);
        acc_cnt++;
        acc_cyc.push_back(hs_cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: expected bytes of one complete frame.
  function automatic void model_frame(input logic [15:0] s, input wq_t w);
    logic [15:0] n;
`ifdef TCP_TX_FRAMER_CHKSUM_EN
    logic [7:0] x;
`endif
    n = 16'(w.size());
    exp_q.push_back(HDR[15:8]);
    exp_q.push_back(HDR[7:0]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    foreach (w[i]) begin
      exp_q.push_back(w[i][31:24]);
      exp_q.push_back(w[i][23:16]);
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
`ifdef TCP_TX_FRAMER_CHKSUM_EN
    x = 8'h00;
    foreach (w[i]) x = x ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    exp_q.push_back(x);
`endif
  endfunction

  task automatic send_frame(input wq_t w);
    for (int i = 0; i < w.size(); i++)
      src_q.push_back({(i == w.size() - 1), w[i]});
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_obs();
    cap_q.delete();
    exp_q.delete();
    acc_cyc.delete();
    wr_in_full = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    seq_m  = 16'h0;
    fcnt_m = 16'h0;
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1; tcp_open = 1'b0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_wr !== 1'b0)      begin failures++; $display("FAIL reset_wr got=%b exp=0", tx_wr); end
    checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL reset_data got=%02h exp=00", tx_data); end
    checks++; if (evt_rdy !== 1'b0)    begin failures++; $display("FAIL reset_rdy got=%b exp=0", evt_rdy); end
    checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%04h exp=0000", frame_cnt); end
    checks++; if (abort_cnt !== 16'h0) begin failures++; $display("FAIL reset_acnt got=%04h exp=0000", abort_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (evt_rdy !== 1'b0 || tx_wr !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle rdy=%b wr=%b exp 0 0", evt_rdy, tx_wr);
    end
    seq_m = 16'h0; fcnt_m = 16'h0;
    clear_obs();
  endtask

  task automatic test_single_frame();
    logic [7:0] lit [10];
    wq_t w;
    lit = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h01};
    clear_obs();
    tcp_open = 1'b1;
    foreach (lit[i]) exp_q.push_back(lit[i]);
`ifdef TCP_TX_FRAMER_CHKSUM_EN
    exp_q.push_back(8'h44);
`endif
    w.push_back(32'h11223344);
    send_frame(w);
    wait_bytes(exp_q.size(), 200);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL single_fcnt got=%0d exp=1", frame_cnt); end
    seq_m = 16'd1; fcnt_m = 16'd1;
  endtask

  task automatic test_back_to_back();
    wq_t w1, w2;
    do_reset();
    tcp_open = 1'b1;
    for (int i = 0; i < 2; i++) begin w1.push_back($urandom()); w2.push_back($urandom()); end
    model_frame(16'h0000, w1);
    model_frame(16'h0001, w2);
    send_frame(w1);
    send_frame(w2);
    wait_bytes(exp_q.size(), 400);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (acc_cyc.size() !== 4) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc_cyc.size());
    end else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 5) begin failures++; $display("FAIL b2b_spacing0 got=%0d exp=5", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_cyc[3] - acc_cyc[2] !== 5) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=5", acc_cyc[3] - acc_cyc[2]); end
    end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL b2b_fcnt got=%0d exp=2", frame_cnt); end
    seq_m = 16'd2; fcnt_m = 16'd2;
  endtask

  task automatic test_full_stall();
    wq_t w;
    int  k = 0;
    clear_obs();
    for (int i = 0; i < 3; i++) w.push_back($urandom());
    model_frame(seq_m, w);
    send_frame(w);
    while (cap_q.size() < 6 && k < 200) begin @(negedge clk); k++; end
    tx_full = 1'b1;
    repeat (3) @(negedge clk);
    tx_full = 1'b0;
    wait_bytes(exp_q.size(), 200);
    checks++; if (wr_in_full !== 0) begin failures++; $display("FAIL stall_wr_in_full got=%0d exp=0", wr_in_full); end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    seq_m++; fcnt_m++;
    checks++; if (frame_cnt !== fcnt_m) begin failures++; $display("FAIL stall_fcnt got=%0d exp=%0d", frame_cnt, fcnt_m); end
  endtask

  task automatic test_abort();
    wq_t w, w1;
    int  base;
    int  k = 0;
    do_reset();
    tcp_open = 1'b1;
    for (int i = 0; i < 4; i++) w.push_back($urandom());
    model_frame(16'h0000, w);
    while (exp_q.size() > 8) exp_q.pop_back();   // header + first word only
    base = acc_cnt;
    send_frame(w);
    while (acc_cnt < base + 2 && k < 200) begin @(negedge clk); k++; end
    tcp_open = 1'b0;
    k = 0;
    while (acc_cnt < base + 4 && k < 200) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    checks++; if (acc_cnt !== base + 4) begin failures++; $display("FAIL abort_flushed got=%0d exp=%0d", acc_cnt - base, 4); end
    checks++; if (abort_cnt !== 16'd1) begin failures++; $display("FAIL abort_cnt got=%0d exp=1", abort_cnt); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL abort_fcnt got=%0d exp=0", frame_cnt); end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL abort_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    clear_obs();
    tcp_open = 1'b1;
    w1.push_back($urandom());
    model_frame(16'h0000, w1);
    send_frame(w1);
    wait_bytes(exp_q.size(), 200);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL abort_next_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_next_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (abort_cnt !== 16'd1 || frame_cnt !== 16'd1) begin
      failures++; $display("FAIL abort_next_cnts acnt=%0d fcnt=%0d exp 1 1", abort_cnt, frame_cnt);
    end
    seq_m = 16'd1; fcnt_m = 16'd1;
  endtask

  task automatic test_closed_idle();
    wq_t w;
    int  bad = 0;
    int  base;
    clear_obs();
    tcp_open = 1'b0;
    for (int i = 0; i < 2; i++) w.push_back($urandom());
    model_frame(seq_m, w);
    base = acc_cnt;
    send_frame(w);
    repeat (100) begin
      @(negedge clk);
      #3;
      if (evt_rdy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL closed_ready_cycles got=%0d exp=0", bad); end
    checks++; if (acc_cnt !== base || cap_q.size() !== 0) begin
      failures++; $display("FAIL closed_activity accepts=%0d bytes=%0d exp 0 0", acc_cnt - base, cap_q.size());
    end
    @(negedge clk);
    tcp_open = 1'b1;
    wait_bytes(exp_q.size(), 200);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL closed_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL closed_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    seq_m++; fcnt_m++;
  endtask

  task automatic test_random();
    int k = 0;
    clear_obs();
    tcp_open = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wq_t w;
      int  n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) w.push_back($urandom());
      model_frame(seq_m, w);
      send_frame(w);
      seq_m++; fcnt_m++;
    end
    while (cap_q.size() < exp_q.size() && k < 2000) begin
      @(negedge clk);
      tx_full = ($urandom_range(0, 3) == 0);
      k++;
    end
    tx_full = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (wr_in_full !== 0) begin failures++; $display("FAIL rand_wr_in_full got=%0d exp=0", wr_in_full); end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== fcnt_m) begin failures++; $display("FAIL rand_fcnt got=%0d exp=%0d", frame_cnt, fcnt_m); end
  endtask

  task automatic test_seq_wrap_and_reset();
    wq_t w1, w2, w3, w4;
    int  k = 0;
    clear_obs();
    tcp_open = 1'b1;
    // Stand-in for sending 65535 frames: place SEQ at the top of its range.
    force dut.seq = 16'hFFFF;
    @(negedge clk);
    release dut.seq;
    @(negedge clk);
    w1.push_back($urandom());
    w2.push_back($urandom());
    model_frame(16'hFFFF, w1);
    model_frame(16'h0000, w2);
    send_frame(w1);
    send_frame(w2);
    wait_bytes(exp_q.size(), 300);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL wrap_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    // Reset in the middle of the payload.
    clear_obs();
    for (int i = 0; i < 3; i++) w3.push_back($urandom());
    send_frame(w3);
    while (cap_q.size() < 5 && k < 200) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_wr !== 1'b0)      begin failures++; $display("FAIL midreset_wr got=%b exp=0", tx_wr); end
    checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL midreset_data got=%02h exp=00", tx_data); end
    checks++; if (evt_rdy !== 1'b0)    begin failures++; $display("FAIL midreset_rdy got=%b exp=0", evt_rdy); end
    checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL midreset_fcnt got=%04h exp=0000", frame_cnt); end
    checks++; if (abort_cnt !== 16'h0) begin failures++; $display("FAIL midreset_acnt got=%04h exp=0000", abort_cnt); end
    src_q.delete();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (evt_rdy !== 1'b0 || tx_wr !== 1'b0) begin
      failures++; $display("FAIL midreset_idle rdy=%b wr=%b exp 0 0", evt_rdy, tx_wr);
    end
    clear_obs();
    w4.push_back($urandom());
    model_frame(16'h0000, w4);
    send_frame(w4);
    wait_bytes(exp_q.size(), 200);
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL after_reset_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL after_reset_byte[%0d] got=%02h exp=%02h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt !== 16'd1 || abort_cnt !== 16'd0) begin
      failures++; $display("FAIL after_reset_cnts fcnt=%0d acnt=%0d exp 1 0", frame_cnt, abort_cnt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tcp_open = 1'b0;
    tx_full  = 1'b0;
    seq_m    = 16'h0;
    fcnt_m   = 16'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_stall();
    test_abort();
    test_closed_idle();
    test_random();
    test_seq_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
